instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00400004, byte address of the first loaded instruction word.
REQ-002 Parameter MAX_WORDS, default 256, largest accepted word count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data is valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
REQ-008 start  input  1  pulse that restarts loading from DONE or ERROR.
REQ-009 mem_we  output  1  one-cycle write strobe to the writable instruction memory.
REQ-010 mem_addr  output  32  byte address of the word being written.
REQ-011 mem_wdata  output  32  instruction word being written.
REQ-012 cpu_hold  output  1  holds the CPU in reset while loading.
REQ-013 load_done  output  1  program loaded successfully.
REQ-014 load_err  output  1  load aborted.

Function
REQ-015 States SHALL be: CNT_HI, CNT_LO, DATA, CSUM, DONE, ERROR.
REQ-016 CNT_HI and CNT_LO SHALL each accept one byte, forming a 16-bit big-endian word count N.
REQ-017 After the CNT_LO byte, the next state SHALL be ERROR if N > MAX_WORDS, otherwise CSUM/DONE (per REQ-031/032) if N == 0, otherwise DATA.
REQ-018 In DATA, every 4 accepted bytes SHALL form one big-endian word, with the first byte going to [31:24].
REQ-019 Word i (0-based) SHALL be written to BASE_ADDR + 4*i.
REQ-020 mem_we SHALL pulse high for exactly one cycle, the cycle after the 4th byte of a word is accepted; mem_addr and mem_wdata are valid in that cycle.
REQ-021 Word index arithmetic SHALL be 16 bits and address arithmetic 32 bits; wrap is unreachable because of REQ-017.
REQ-022 rx_ready SHALL be 1 in CNT_HI, CNT_LO, DATA and CSUM, and 0 in DONE and ERROR; byte acceptance is one byte per cycle maximum with no stall.
REQ-023 After the 4th byte of word N-1, the next state SHALL be CSUM or DONE; that word's mem_we still fires.
REQ-024 DONE: cpu_hold=0, load_done=1. ERROR: cpu_hold=1, load_err=1.
REQ-025 In any other state: cpu_hold=1, load_done=0, load_err=0.
REQ-026 start SHALL be ignored except in DONE or ERROR, where it moves to CNT_HI and clears the byte, word and checksum counters.
REQ-027 rx_valid while rx_ready=0 SHALL have no effect.

Reset
REQ-028 Reset SHALL force state CNT_HI and clear all counters, the partial word and the checksum.
REQ-029 Reset output values: cpu_hold=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, load_done=0, load_err=0.
REQ-030 Reset asserted mid-load SHALL discard the partial word with no write strobe; words already written are not retracted.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined: a running XOR covers every byte, including the count bytes. After the last word (or after the count when N==0), CSUM accepts one byte; a match moves to DONE, a mismatch to ERROR.
REQ-032 With LOADER_CHECKSUM_EN undefined: CSUM is unreachable, and the transition goes directly to DONE.

Structure
REQ-033 Package instr_loader_pkg SHALL hold the state enum typedef, the default BASE_ADDR and MAX_WORDS constants, and the checksum-byte width constant.
REQ-034 One sub-module, word_assembler, SHALL perform the 4-byte shift into a word and its completion flag; the FSM, counters and outputs stay in instr_mem_loader.

Verification
REQ-035 Bytes 00 01 3c 01 40 00 (checksum off) -> one mem_we with addr 0x00400004, data 0x3c014000; then load_done=1, cpu_hold=0.
REQ-036 N=2 with words 0x3c014000 and 0x34280000, bytes sent with random rx_valid gaps -> writes at 0x00400004 and 0x00400008 only, each mem_we exactly one cycle.
REQ-037 Count bytes 01 01 (N=257 > 256) -> ERROR, load_err=1, rx_ready=0, no mem_we.
REQ-038 LOADER_CHECKSUM_EN, bytes 00 01 3c 01 40 00 7c -> DONE. Same stream ending 00 -> ERROR, yet the word write still occurred.
REQ-039 Reset after 2 data bytes, then start-free reload of 00 01 08 10 00 8e -> single write of 0x0810008e at 0x00400004.
REQ-040 start in DONE -> CNT_HI next cycle, cpu_hold=1; start in DATA -> no effect.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// The checksum stage is only active when LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0004;
    localparam int unsigned DEF_MAX_WORDS = 256;
    localparam int unsigned CSUM_W        = 8;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_t;

    // Byte address of word idx relative to base.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian byte-to-word shifter: the first byte of each group of four lands in [31:24].
// o_word/o_word_done are combinational so the caller can register the word on the 4th byte.
module word_assembler (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed program into instruction memory while holding the CPU in reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        start,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = CSUM;
`else
    localparam loader_state_t END_STATE = DONE;
`endif

    loader_state_t r_state;
    logic [15:0]   r_count;
    logic [15:0]   r_word_idx;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;

    logic          w_accept;
    logic          w_restart;
    logic          w_asm_valid;
    logic [15:0]   w_count_n;
    logic          w_word_last;
    logic [31:0]   w_word;
    logic          w_word_done;

    assign rx_ready    = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                         (r_state == DATA)   || (r_state == CSUM);
    assign w_accept    = rx_valid && rx_ready;
    assign w_restart   = start && ((r_state == DONE) || (r_state == ERROR));
    assign w_asm_valid = w_accept && (r_state == DATA);
    assign w_count_n   = {r_count[15:8], rx_data};
    assign w_word_last = (r_word_idx == (r_count - 16'd1));

    word_assembler u_asm (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_restart),
        .i_valid     (w_asm_valid),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] r_csum;

    // The checksum byte itself is excluded from the running XOR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_restart) begin
            r_csum <= '0;
        end else if (w_accept && (r_state != CSUM)) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= CNT_HI;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                CNT_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= rx_data;
                        r_state       <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (w_accept) begin
                        r_count <= w_count_n;
                        if ({16'd0, w_count_n} > MAX_WORDS) begin
                            r_state <= ERROR;
                        end else if (w_count_n == 16'd0) begin
                            r_state <= END_STATE;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_done) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= word_addr(BASE_ADDR, r_word_idx);
                        r_mem_wdata <= w_word;
                        r_word_idx  <= r_word_idx + 16'd1;
                        if (w_word_last) begin
                            r_state <= END_STATE;
                        end
                    end
                end
                CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_accept) begin
                        r_state <= (rx_data == r_csum) ? DONE : ERROR;
                    end
`else
                    r_state <= ERROR;
`endif
                end
                DONE, ERROR: begin
                    if (start) begin
                        r_state    <= CNT_HI;
                        r_count    <= '0;
                        r_word_idx <= '0;
                    end
                end
                default: r_state <= CNT_HI;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = (r_state != DONE);
    assign load_done = (r_state == DONE);
    assign load_err  = (r_state == ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default parameters).
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum stage.
module tb_instr_mem_loader;

    localparam logic [31:0] BASE = 32'h0040_0004;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [31:0] wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    int unsigned wr_n = 0;
    logic [7:0]  tx_csum;

    instr_mem_loader #(.BASE_ADDR(32'h0040_0004), .MAX_WORDS(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every high cycle of mem_we is logged, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && wr_n < 512) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_n = wr_n + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        tx_csum  = tx_csum ^ b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = tx_csum;
        send_byte(c, 0);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        tx_csum = 8'h00;
    endtask

    function automatic logic [31:0] pat_word(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'h01, b ^ 8'h02, b ^ 8'h03};
    endfunction

    initial begin
        int unsigned base_n;
        logic [7:0]  v1 [0:9];
        logic [7:0]  b;

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        tx_csum  = 8'h00;

        // Reset values
        wait_neg();
        check_val("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("rst_mem_addr", mem_addr, BASE);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_load_done", {31'd0, load_done}, 32'd0);
        check_val("rst_load_err", {31'd0, load_err}, 32'd0);
        check_val("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-word program
        base_n = wr_n;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h3c, 0); send_byte(8'h01, 0);
        send_byte(8'h40, 0); send_byte(8'h00, 0);
`ifndef LOADER_CHECKSUM_EN
        wait_neg();
        check_val("w1_strobe_on", {31'd0, mem_we}, 32'd1);
        wait_neg();
        check_val("w1_strobe_off", {31'd0, mem_we}, 32'd0);
`endif
        finish_load();
        wait_neg();
        check_val("w1_done", {31'd0, load_done}, 32'd1);
        check_val("w1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check_val("w1_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_val("w1_nwrites", wr_n - base_n, 32'd1);
        check_val("w1_addr", wr_addr[base_n], 32'h0040_0004);
        check_val("w1_data", wr_data[base_n], 32'h3c01_4000);

        // start in DONE returns to CNT_HI
        pulse_start();
        wait_neg();
        check_val("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("restart_done", {31'd0, load_done}, 32'd0);
        check_val("restart_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Two words with random valid gaps; start mid-DATA must be ignored
        v1[0] = 8'h00; v1[1] = 8'h02;
        v1[2] = 8'h3c; v1[3] = 8'h01; v1[4] = 8'h40; v1[5] = 8'h00;
        v1[6] = 8'h34; v1[7] = 8'h28; v1[8] = 8'h00; v1[9] = 8'h00;
        base_n = wr_n;
        for (int i = 0; i < 10; i++) begin
            send_byte(v1[i], $urandom_range(0, 3));
            if (i == 6) begin
                pulse_start();
                tx_csum = 8'h00 ^ 8'h02 ^ 8'h3c ^ 8'h01 ^ 8'h40 ^ 8'h00 ^ 8'h34;
            end
        end
        finish_load();
        wait_neg();
        wait_neg();
        check_val("w2_done", {31'd0, load_done}, 32'd1);
        check_val("w2_nwrites", wr_n - base_n, 32'd2);
        check_val("w2_addr0", wr_addr[base_n], 32'h0040_0004);
        check_val("w2_data0", wr_data[base_n], 32'h3c01_4000);
        check_val("w2_addr1", wr_addr[base_n+1], 32'h0040_0008);
        check_val("w2_data1", wr_data[base_n+1], 32'h3428_0000);

        // Count 257 exceeds MAX_WORDS
        pulse_start();
        base_n = wr_n;
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        wait_neg();
        check_val("ovf_err", {31'd0, load_err}, 32'd1);
        check_val("ovf_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_val("ovf_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("ovf_done", {31'd0, load_done}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h55, 0);
        wait_neg();
        check_val("ovf_still_err", {31'd0, load_err}, 32'd1);
        check_val("ovf_nwrites", wr_n - base_n, 32'd0);

        // Reset mid-load discards partial word; reload needs no start
        pulse_start();
        check_val("err_restart", {31'd0, load_err}, 32'd0);
        base_n = wr_n;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h08, 0); send_byte(8'h10, 0);
        reset = 1'b1;
        wait_neg();
        check_val("midrst_we", {31'd0, mem_we}, 32'd0);
        check_val("midrst_addr", mem_addr, BASE);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        tx_csum = 8'h00;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h08, 0); send_byte(8'h10, 0);
        send_byte(8'h00, 0); send_byte(8'h8e, 0);
        finish_load();
        wait_neg();
        wait_neg();
        check_val("reload_done", {31'd0, load_done}, 32'd1);
        check_val("reload_nwrites", wr_n - base_n, 32'd1);
        check_val("reload_addr", wr_addr[base_n], 32'h0040_0004);
        check_val("reload_data", wr_data[base_n], 32'h0810_008e);

        // Empty program
        pulse_start();
        base_n = wr_n;
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        finish_load();
        wait_neg();
        check_val("n0_done", {31'd0, load_done}, 32'd1);
        check_val("n0_nwrites", wr_n - base_n, 32'd0);

        // Exactly MAX_WORDS words is accepted
        pulse_start();
        base_n = wr_n;
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        wait_neg();
        check_val("max_not_err", {31'd0, load_err}, 32'd0);
        check_val("max_rx_ready", {31'd0, rx_ready}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(i) ^ 8'(k);
                send_byte(b, 0);
            end
        end
        finish_load();
        wait_neg();
        wait_neg();
        check_val("max_done", {31'd0, load_done}, 32'd1);
        check_val("max_nwrites", wr_n - base_n, 32'd256);
        check_val("max_last_addr", wr_addr[base_n+255], 32'h0040_0400);
        check_val("max_last_data", wr_data[base_n+255], 32'hfffe_fdfc);
        for (int i = 0; i < 256; i += 37) begin
            check_val("max_addr_i", wr_addr[base_n+i], BASE + 32'(4 * i));
            check_val("max_data_i", wr_data[base_n+i], pat_word(i));
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h3c, 0); send_byte(8'h01, 0);
        send_byte(8'h40, 0); send_byte(8'h00, 0);
        send_byte(8'h7c, 0);
        wait_neg();
        check_val("cs_ok_done", {31'd0, load_done}, 32'd1);
        pulse_start();
        base_n = wr_n;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h3c, 0); send_byte(8'h01, 0);
        send_byte(8'h40, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_neg();
        check_val("cs_bad_err", {31'd0, load_err}, 32'd1);
        check_val("cs_bad_nwrites", wr_n - base_n, 32'd1);
        check_val("cs_bad_data", wr_data[base_n], 32'h3c01_4000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
